// File: rtl/din_debounce_pulse_if.sv
// Signal bundle for the button debouncer: raw line in, conditioned level and pulses out.
// The debouncer uses the slave view; whatever drives the raw line uses the master view.
interface din_debounce_pulse_if;
  logic btn_in;
  logic level_out;
  logic press_pulse;
  logic release_pulse;
  logic busy;

  modport master (
    output btn_in,
    input  level_out,
    input  press_pulse,
    input  release_pulse,
    input  busy
  );

  modport slave (
    input  btn_in,
    output level_out,
    output press_pulse,
    output release_pulse,
    output busy
  );
endinterface

// File: rtl/din_debounce_pulse.sv
// Push-button conditioner: synchroniser, stability counter and a Moore FSM that
// emits a debounced level plus single-cycle press/release pulses.
//
// state      | meaning
// S_LOW      | settled low, waiting for a rising candidate
// S_RISE_CHK | qualifying a rising candidate (busy)
// S_PRESS    | accepted rise, press_pulse for one cycle
// S_HIGH     | settled high, waiting for a falling candidate
// S_FALL_CHK | qualifying a falling candidate (busy, level still high)
// S_RELEASE  | accepted fall, release_pulse for one cycle
module din_debounce_pulse #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  din_debounce_pulse_if.slave   bus
);

  typedef enum logic [2:0] {
    S_LOW      = 3'd0,
    S_RISE_CHK = 3'd1,
    S_PRESS    = 3'd2,
    S_HIGH     = 3'd3,
    S_FALL_CHK = 3'd4,
    S_RELEASE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter only advances inside a CHK state; every other path parks it at zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      S_LOW: begin
        if (btn_s) state_nxt = S_RISE_CHK;
      end
      S_RISE_CHK: begin
        if (!btn_s) begin
          state_nxt = S_LOW;
        end else if (cnt == CNT_TC) begin
          state_nxt = S_PRESS;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_PRESS: begin
        state_nxt = S_HIGH;
      end
      S_HIGH: begin
        if (!btn_s) state_nxt = S_FALL_CHK;
      end
      S_FALL_CHK: begin
        if (btn_s) begin
          state_nxt = S_HIGH;
        end else if (cnt == CNT_TC) begin
          state_nxt = S_RELEASE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        state_nxt = S_LOW;
      end
      default: begin
        state_nxt = S_LOW;
      end
    endcase
  end

  assign bus.level_out     = (state == S_PRESS) || (state == S_HIGH) || (state == S_FALL_CHK);
  assign bus.press_pulse   = (state == S_PRESS);
  assign bus.release_pulse = (state == S_RELEASE);
  assign bus.busy          = (state == S_RISE_CHK) || (state == S_FALL_CHK);

endmodule

// File: doc/din_debounce_pulse.md
Name: din_debounce_pulse

Overview:
- Input conditioner for a raw asynchronous push-button or switch line.
- Synchronises the line into clk, rejects bounce shorter than DEBOUNCE_CYCLES, and emits a debounced level plus single-cycle press/release pulses.
- press_pulse drives the din input of the downstream 2-state toggle Moore FSM, so each physical press toggles that FSM exactly once.
- The block is itself a Moore machine: all outputs are decoded from state only.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn_in; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a transition; legal range 1..(2^CNT_W - 1).
- CNT_W, 8, width of the stability counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- btn_in  input  1  raw asynchronous button/switch line; may bounce.
- level_out  output  1  debounced level.
- press_pulse  output  1  one-cycle pulse on each accepted 0->1 transition.
- release_pulse  output  1  one-cycle pulse on each accepted 1->0 transition.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Reset (async assert, sync release):
  - all synchroniser flops cleared to 0, counter 0, state S_LOW.
  - all outputs 0.
  - If btn_in is held high across reset release, this is treated as a new press and follows the normal latency.
- Synchroniser: SYNC_STAGES-flop chain; the last flop is btn_s. The FSM sees only btn_s.
- States and next-state rules (evaluated at posedge clk):
  - S_LOW: btn_s=1 -> S_RISE_CHK, cnt<=0. Otherwise stay.
  - S_RISE_CHK:
    - btn_s=0 -> S_LOW (bounce rejected), cnt<=0.
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> S_PRESS.
    - Otherwise cnt<=cnt+1.
  - S_PRESS: unconditionally -> S_HIGH.
  - S_HIGH: btn_s=0 -> S_FALL_CHK, cnt<=0. Otherwise stay.
  - S_FALL_CHK:
    - btn_s=1 -> S_HIGH (bounce rejected), cnt<=0.
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> S_RELEASE.
    - Otherwise cnt<=cnt+1.
  - S_RELEASE: unconditionally -> S_LOW.
  - Unused encodings -> S_LOW.
- Output decode (Moore, from state only):
  - level_out=1 in S_PRESS, S_HIGH and S_FALL_CHK; 0 elsewhere.
  - press_pulse=1 only in S_PRESS.
  - release_pulse=1 only in S_RELEASE.
  - busy=1 in S_RISE_CHK and S_FALL_CHK.
- Latency:
  - Let btn_in meet setup for edge 1.
  - press_pulse is high in the cycle following edge SYNC_STAGES+1+DEBOUNCE_CYCLES.
  - With defaults, that is after edge 19, for exactly one cycle.
  - Release latency is identical.
- Pulse width and spacing:
  - press_pulse and release_pulse are never high together.
  - Each is exactly one cycle wide.
  - The minimum spacing between a press and the following release is DEBOUNCE_CYCLES+2 cycles.
- Counter: saturation is never reached, because the transition fires at DEBOUNCE_CYCLES-1. The counter is held at 0 in S_LOW, S_HIGH, S_PRESS and S_RELEASE.
- Boundary cases:
  - An input drop during S_PRESS is not sampled. The following S_HIGH then starts fall qualification on the next edge.
  - DEBOUNCE_CYCLES=1: a transition is accepted after a single cycle in the CHK state.
  - Reset mid-qualification: immediate return to S_LOW with no pulse emitted. A pulse cycle truncated by reset is not replayed.

Test Plan:
- Reset with btn_in=0, hold 5 cycles -> level_out=0, press_pulse=0, release_pulse=0, busy=0 throughout.
- Clean press: btn_in 0->1 before edge 1, held 40 cycles (defaults) -> busy high after edges 3..18; press_pulse=1 only in the cycle after edge 19; level_out=1 from edge 19 onward.
- Bounce rejection: btn_in toggles high 5 cycles / low 3 cycles, repeated 6 times, then stays low -> no press_pulse, level_out stays 0, busy pulses each burst.
- Bouncy press: 4 short glitches, then stable high 30 cycles -> exactly one press_pulse, 17 cycles after btn_s last rose; later clean release -> exactly one release_pulse; level_out returns to 0 the same cycle.
- Reset mid-check: assert rst during S_RISE_CHK (cnt=10) -> all outputs 0 immediately. After release with btn_in still high -> press_pulse after full latency (edge 19 after release).
- Downstream chain: connect press_pulse to the toggle Moore FSM din and apply 3 bouncy presses -> the FSM dout toggles exactly 3 times, ending at 1.
